phi1_mul_stream: RTL
====================

# phi1_mul_stream

Streaming multiplier by Φ1 = (x − 1) in Z[x]/(x^N − 1) for the poly-lift datapath. It sits directly downstream of the Φ1-inverse ternary stage. It consumes the S3 result v two ternary coefficients per beat and emits w = (x − 1)·v with coefficients reduced mod q (w_i = v_{i−1} − v_i, indices cyclic). Output uses a one-beat lag and a one-entry output register with a valid/ready handshake, so no full-polynomial buffer is needed.

## Interface
- N, 701, polynomial length; odd, ≥ 3
- LOGQ, 13, output coefficient width; q = 2^LOGQ
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat when in_valid & in_ready
- in_coef  in  4  two ternary coefficients: [1:0] = v_2k, [3:2] = v_2k+1; on the final beat only [1:0] is meaningful
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_coef  out  2*LOGQ  lane0 in [LOGQ-1:0], lane1 in [2*LOGQ-1:LOGQ]; values are mod q
- out_lane1_vld  out  1  lane1 carries a coefficient
- out_last  out  1  final beat of the polynomial

## Operation
- Ternary encoding: 00 = 0, 01 = +1, 11 = −1. Illegal code 10 decodes as 0.
- Differences lie in {−2..2} and map mod q: −2 → q−2, −1 → q−1, 0..2 unchanged.
- NB = (N+1)/2 input beats per polynomial: beats 0..NB−2 carry pairs; beat NB−1 carries v_{N−1} alone.
- Output order: w_1, w_2, …, w_{N−1}, then w_0. This gives NB beats in total.
  - Beats 0..NB−2 have both lanes valid: (w_{2j+1}, w_{2j+2}).
  - Beat NB−1 is {w_0, lane1 invalid, out_last = 1}.
- Registers:
  - prev holds the last accepted input pair.
  - v0 holds v_0, captured on beat 0.
  - beat counter, width $clog2(NB).
- FSM:
  - S_FIRST: in_ready = 1. On accept, capture prev and v0, set cnt = 1, go to S_STREAM. No output is produced.
  - S_STREAM: in_ready = !out_valid | out_ready. On accepting beat k, load the output register with (prev.lo − prev.hi, prev.hi − in.lo), update prev, increment cnt. If k = NB−1, go to S_TAIL.
  - S_TAIL: in_ready = 0. The output register holds beat NB−2. On an output handshake, load {v_{N−1} − v_0, lane1 = 0, last = 1} and go to S_LAST.
  - S_LAST: in_ready = 0. On an output handshake, clear out_valid and go to S_FIRST.
- Output register: out_valid sets on load and clears on a handshake with no simultaneous load. A load and a handshake in the same cycle are legal; new data replaces old with no bubble.
- out_valid stays high and out_coef stays stable while out_ready = 0.

## Timing
- Reset values: state = S_FIRST, out_valid = 0, out_coef = 0, out_lane1_vld = 0, out_last = 0, cnt = 0, prev = 0, v0 = 0. in_ready = 1 in the cycle after reset.
- Reset mid-polynomial discards all partial state. No output is emitted for the aborted polynomial.
- Latency: accepting input beat k (k ≥ 1) makes output beat k−1 visible on the next cycle.
- w_0 appears one cycle after beat NB−2 is accepted downstream.
- Throughput: 1 beat/cycle with out_ready held high, plus 2 tail cycles per polynomial.
- in_ready depends combinationally on out_ready (no skid buffer). in_valid must not depend on in_ready.

## Structure
- Shared package ter_pkg holds:
  - constants TER_ZERO, TER_POS, TER_NEG;
  - function ter_to_int (2-bit code → signed 2-bit, illegal → 0);
  - state enum phi1_mul_state_t.
- Sub-module ter_diff_modq (combinational: a, b ternary → LOGQ-bit (a − b) mod q). Two instances are used; lane0's instance is muxed to (v_{N−1}, v_0) in S_TAIL.

## Test plan
- N=5, v = [1,0,−1,1,−1], input beats (01,00), (11,01), (11,xx), out_ready = 1 → outputs (1,1), (8190,2), then {8190, lane1 invalid, last}.
- N=5, all-zero input → three beats of zeros; only the final beat has out_last = 1 and out_lane1_vld = 0.
- N=701, v all +1 → 351 beats, all coefficients 0. in_ready is held low for exactly 2 cycles at the tail.
- Same vector as the first case with out_ready toggling 1010… → identical sequence. Outputs stay stable while stalled, and in_ready = 0 whenever out_valid & !out_ready in S_STREAM.
- rst_n low for 1 cycle after beat 1 of a 5-coefficient polynomial, then a fresh vector → only the fresh polynomial's 3 beats appear.
- Illegal code 10 in v_1 of the first vector → identical to v_1 = 0 (outputs (1,1), …).

Source files
------------

// File: rtl/ter_pkg.sv
// rtl/ter_pkg.sv - ternary coefficient helpers and phi1 multiplier state encoding
//
// Shared by the poly-lift datapath blocks that consume ternary coefficients.
// Ternary code: 00 = 0, 01 = +1, 11 = -1; the unused code 10 reads as 0 so a
// corrupted coefficient degrades to zero instead of a spurious sign.

package ter_pkg;

   localparam logic [1:0] TER_ZERO = 2'b00;
   localparam logic [1:0] TER_POS  = 2'b01;
   localparam logic [1:0] TER_NEG  = 2'b11;

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_STREAM = 2'd1,
      S_TAIL   = 2'd2,
      S_LAST   = 2'd3
   } phi1_mul_state_t;

   // 2-bit ternary code to a signed 2-bit value in {-1, 0, +1}.
   function automatic logic signed [1:0] ter_to_int(input logic [1:0] code);
      logic signed [1:0] val;
      case (code)
         TER_POS: val = 2'sb01;
         TER_NEG: val = 2'sb11;
         default: val = 2'sb00;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/ter_diff_modq.sv
// rtl/ter_diff_modq.sv - combinational (a - b) mod 2^LOGQ for ternary operands
//
// Ports:
//   a, b  in   2      ternary codes
//   d     out  LOGQ   (a - b) mod q, q = 2^LOGQ
//
// The difference lies in -2..2 and fits a 3-bit two's-complement value;
// sign-extending it to LOGQ bits is exactly the reduction mod 2^LOGQ
// (-2 -> q-2, -1 -> q-1).

module ter_diff_modq
   import ter_pkg::*;
#(
   parameter int LOGQ = 13
) (
   input  logic [1:0]      a,
   input  logic [1:0]      b,
   output logic [LOGQ-1:0] d
);

   logic signed [1:0] a_val;
   logic signed [1:0] b_val;
   logic [2:0]        diff;

   always_comb begin
      a_val = ter_to_int(a);
      b_val = ter_to_int(b);
      diff  = {a_val[1], a_val} - {b_val[1], b_val};
      d     = {{(LOGQ-3){diff[2]}}, diff};
   end

endmodule

// File: rtl/phi1_mul_stream.sv
// rtl/phi1_mul_stream.sv - streaming multiply by (x - 1) in Z[x]/(x^N - 1), coefficients mod 2^LOGQ
//
// Consumes v two ternary coefficients per beat and emits w_i = v_{i-1} - v_i
// in the order w_1 .. w_{N-1}, w_0, two lanes per beat.
//
// Ports:
//   clk            in   1         rising-edge clock
//   rst_n          in   1         synchronous active-low reset
//   in_valid       in   1         input beat valid
//   in_ready       out  1         input accepted when in_valid & in_ready
//   in_coef        in   4         [1:0] = v_2k, [3:2] = v_2k+1 (final beat: [1:0] only)
//   out_valid      out  1         output beat valid
//   out_ready      in   1         output accepted when out_valid & out_ready
//   out_coef       out  2*LOGQ    lane0 [LOGQ-1:0], lane1 [2*LOGQ-1:LOGQ]
//   out_lane1_vld  out  1         lane1 carries a coefficient
//   out_last       out  1         final beat of the polynomial
//
// Output beat k-1 needs v_{2k}, so output lags input by one beat; the lag
// plus the single output register replaces a full-polynomial buffer. w_0
// wraps around to v_0, which is kept from beat 0 and emitted last.

module phi1_mul_stream
   import ter_pkg::*;
#(
   parameter int N    = 701,
   parameter int LOGQ = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*LOGQ-1:0] out_coef,
   output logic              out_lane1_vld,
   output logic              out_last
);

   localparam int NB    = (N + 1) / 2;
   localparam int CNT_W = $clog2(NB);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

   phi1_mul_state_t  state;
   logic [3:0]       prev;
   logic [1:0]       v0;
   logic [CNT_W-1:0] cnt;

   logic             in_acc;
   logic             out_hs;
   logic [1:0]       lane0_a;
   logic [1:0]       lane0_b;
   logic [LOGQ-1:0]  lane0_d;
   logic [LOGQ-1:0]  lane1_d;

   assign in_acc = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   // No skid buffer: in STREAM a beat is taken only if the output register
   // is empty or being drained this cycle.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_FIRST:  in_ready = 1'b1;
         S_STREAM: in_ready = ~out_valid | out_ready;
         default:  in_ready = 1'b0;
      endcase
   end

   // Lane0 normally forms prev.lo - prev.hi; in TAIL prev.lo is v_{N-1}
   // and the subtrahend switches to v_0 to produce the wrap-around w_0.
   always_comb begin
      lane0_a = prev[1:0];
      lane0_b = (state == S_TAIL) ? v0 : prev[3:2];
   end

   ter_diff_modq #(.LOGQ(LOGQ)) u_diff_lane0 (
      .a (lane0_a),
      .b (lane0_b),
      .d (lane0_d)
   );

   ter_diff_modq #(.LOGQ(LOGQ)) u_diff_lane1 (
      .a (prev[3:2]),
      .b (in_coef[1:0]),
      .d (lane1_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_FIRST;
         prev          <= 4'b0;
         v0            <= 2'b0;
         cnt           <= '0;
         out_valid     <= 1'b0;
         out_coef      <= '0;
         out_lane1_vld <= 1'b0;
         out_last      <= 1'b0;
      end else begin
         case (state)
            S_FIRST: begin
               if (in_acc) begin
                  prev  <= in_coef;
                  v0    <= in_coef[1:0];
                  cnt   <= CNT_W'(1);
                  state <= S_STREAM;
               end
            end

            S_STREAM: begin
               if (in_acc) begin
                  // A load may coincide with a drain; new data replaces old.
                  out_valid     <= 1'b1;
                  out_coef      <= {lane1_d, lane0_d};
                  out_lane1_vld <= 1'b1;
                  out_last      <= 1'b0;
                  prev          <= in_coef;
                  cnt           <= cnt + CNT_W'(1);
                  if (cnt == LAST_BEAT) begin
                     state <= S_TAIL;
                  end
               end else if (out_hs) begin
                  out_valid <= 1'b0;
               end
            end

            S_TAIL: begin
               // Output register holds beat NB-2; w_0 follows once it drains.
               if (out_hs) begin
                  out_valid     <= 1'b1;
                  out_coef      <= {{LOGQ{1'b0}}, lane0_d};
                  out_lane1_vld <= 1'b0;
                  out_last      <= 1'b1;
                  state         <= S_LAST;
               end
            end

            S_LAST: begin
               if (out_hs) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  cnt       <= '0;
                  state     <= S_FIRST;
               end
            end

            default: state <= S_FIRST;
         endcase
      end
   end

endmodule
